// File: rtl/cmd_arbiter.sv
// Round-robin command arbiter: grants one of NREQ requesters, drives the command bus
// to the executors, and reports completion, timeout or illegal-command per requester.
module cmd_arbiter #(
  parameter int NREQ  = 4,
  parameter int CSIZE = 4,
  parameter int LSIZE = 24,
  parameter int SLIZE = 16,
  parameter int TMO   = 65535
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*CSIZE-1:0]  req_cmd,
  input  logic [NREQ*LSIZE-1:0]  req_len,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        req_done,
  output logic [NREQ-1:0]        req_err,
  output logic                   request,
  output logic [CSIZE-1:0]       cmd,
  output logic [LSIZE-1:0]       len,
  input  logic [SLIZE-1:0]       busy,
  input  logic [SLIZE-1:0]       finish
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     sel_q, sel_d, last_q, last_d;
  logic [CSIZE-1:0]  cmd_q, cmd_d;
  logic [LSIZE-1:0]  len_q, len_d;
  logic              request_q, request_d;
  logic [NREQ-1:0]   ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NREQ-1:0]   elig;
  logic [GW-1:0]     pick, idx;
  logic              found;
  logic [CSIZE-1:0]  pick_cmd;
  logic [LSIZE-1:0]  pick_len;
  logic              pick_bad;
  logic [SLIZE-1:0]  busy_sh, fin_sh;
  logic              busy_hit, fin_hit;

  // A requester whose accept pulse is on the bus this cycle is not re-granted.
  assign elig = req_valid & ~ready_q;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last_q) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_cmd = req_cmd[int'(pick)*CSIZE +: CSIZE];
  assign pick_len = req_len[int'(pick)*LSIZE +: LSIZE];
  assign pick_bad = (int'(pick_cmd) >= SLIZE);

  // Only the executor addressed by the latched command is observed.
  assign busy_sh  = busy >> cmd_q;
  assign fin_sh   = finish >> cmd_q;
  assign busy_hit = busy_sh[0];
  assign fin_hit  = fin_sh[0];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    request_d = request_q;
    cnt_d     = cnt_q;
    ready_d   = '0;
    done_d    = '0;
    err_d     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d         = pick;
          cmd_d         = pick_cmd;
          len_d         = pick_len;
          ready_d[pick] = 1'b1;
          if (pick_bad) begin
            err_d[pick] = 1'b1;
            last_d      = pick;
          end else begin
            request_d = 1'b1;
            cnt_d     = '0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE, WAIT_FIN: begin
        cnt_d = cnt_q + CW'(1);
        // Finish takes precedence over a timeout landing on the same edge.
        if (fin_hit) begin
          state_d       = DONE;
          request_d     = 1'b0;
          done_d[sel_q] = 1'b1;
        end else if (cnt_q == CW'(TMO - 1)) begin
          state_d      = IDLE;
          request_d    = 1'b0;
          err_d[sel_q] = 1'b1;
          last_d       = sel_q;
        end else if (state_q == ISSUE && busy_hit) begin
          state_d   = WAIT_FIN;
          request_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = sel_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= GW'(NREQ - 1);
      cmd_q     <= '0;
      len_q     <= '0;
      request_q <= 1'b0;
      ready_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      request_q <= request_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready = ready_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign request   = request_q;
  assign cmd       = cmd_q;
  assign len       = len_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level round-robin reference model.
module tb_cmd_arbiter;

  localparam int NREQ  = 4;
  localparam int CSIZE = 4;
  localparam int LSIZE = 24;
  localparam int SLIZE = 8;
  localparam int TMO   = 20;

  logic                  clock = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*CSIZE-1:0] req_cmd = '0;
  logic [NREQ*LSIZE-1:0] req_len = '0;
  logic [NREQ-1:0]       req_ready, req_done, req_err;
  logic                  request;
  logic [CSIZE-1:0]      cmd;
  logic [LSIZE-1:0]      len;
  logic [SLIZE-1:0]      busy = '0;
  logic [SLIZE-1:0]      finish = '0;

  cmd_arbiter #(
    .NREQ(NREQ), .CSIZE(CSIZE), .LSIZE(LSIZE), .SLIZE(SLIZE), .TMO(TMO)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_len(req_len),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .request(request), .cmd(cmd), .len(len),
    .busy(busy), .finish(finish)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: priority list (front = highest), the in-flight owner,
  // and how many cycles the owner's command has spent on the bus.
  int               prio[$];
  int               owner;
  bit               acked, cool;
  int               age;
  logic [NREQ-1:0]  e_ready, e_done, e_err;
  logic             e_req;
  logic [CSIZE-1:0] e_cmd;
  logic [LSIZE-1:0] e_len;

  function automatic void m_reset();
    prio.delete();
    for (int i = 0; i < NREQ; i++) prio.push_back(i);
    owner = -1; acked = 0; cool = 0; age = 0;
    e_ready = '0; e_done = '0; e_err = '0; e_req = 1'b0; e_cmd = '0; e_len = '0;
  endfunction

  function automatic void m_demote(input int g);
    int x;
    while (prio[prio.size()-1] != g) begin
      x = prio.pop_front();
      prio.push_back(x);
    end
  endfunction

  function automatic void m_step();
    logic [NREQ-1:0]  elig, nr, nd, ne;
    logic [SLIZE-1:0] fsh, bsh;
    int g;
    elig = req_valid & ~e_ready;
    nr = '0; nd = '0; ne = '0;
    if (cool) begin
      cool = 0;
      m_demote(owner);
      owner = -1;
    end else if (owner < 0) begin
      g = -1;
      foreach (prio[k]) if (g < 0 && elig[prio[k]]) g = prio[k];
      if (g >= 0) begin
        e_cmd = req_cmd[g*CSIZE +: CSIZE];
        e_len = req_len[g*LSIZE +: LSIZE];
        nr[g] = 1'b1;
        if (int'(e_cmd) >= SLIZE) begin
          ne[g] = 1'b1;
          m_demote(g);
        end else begin
          owner = g; age = 0; acked = 0; e_req = 1'b1;
        end
      end
    end else begin
      age++;
      fsh = finish >> e_cmd;
      bsh = busy >> e_cmd;
      if (fsh[0]) begin
        nd[owner] = 1'b1; e_req = 1'b0; cool = 1;
      end else if (age == TMO) begin
        ne[owner] = 1'b1; e_req = 1'b0;
        m_demote(owner);
        owner = -1;
      end else if (!acked && bsh[0]) begin
        acked = 1; e_req = 1'b0;
      end
    end
    e_ready = nr; e_done = nd; e_err = ne;
  endfunction

  task automatic compare_all();
    check("request", 64'(request), 64'(e_req));
    check("cmd", 64'(cmd), 64'(e_cmd));
    check("len", 64'(len), 64'(e_len));
    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("req_done", 64'(req_done), 64'(e_done));
    check("req_err", 64'(req_err), 64'(e_err));
  endtask

  // Inputs are set before calling; returns at the following falling edge.
  task automatic step();
    m_step();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    @(posedge clock);
    @(negedge clock);
    compare_all();
    rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  initial begin
    int grants[$];
    int t_r, t_e, t_r3, gi;
    logic req_at_e;

    #2;
    do_reset();

    // Single requester, executor busy at cycle 2, finish at cycle 10.
    req_valid = 4'b0001;
    req_cmd[0*CSIZE +: CSIZE] = 4'd3;
    req_len[0*LSIZE +: LSIZE] = 24'd256;
    for (int t = 1; t <= 12; t++) begin
      step();
      if (t == 1) check("r17_ready", 64'(req_ready), 64'(4'b0001));
      if (t == 1 || t == 2) check("r17_req_hi", 64'(request), 64'(1));
      if (t == 3) check("r17_req_lo", 64'(request), 64'(0));
      if (t == 11) check("r17_done", 64'(req_done), 64'(4'b0001));
      req_valid &= ~e_ready;
      busy   = (t >= 2 && t <= 10) ? 8'h08 : 8'h00;
      finish = (t == 10) ? 8'h08 : 8'h00;
    end

    // All requesters pending, executors finishing immediately.
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) req_cmd[i*CSIZE +: CSIZE] = CSIZE'(i + 1);
    busy = '1; finish = '1;
    for (int t = 1; t <= 16; t++) begin
      step();
      gi = onehot_idx(req_ready);
      if (gi >= 0) grants.push_back(gi);
    end
    check("r18_count", 64'(grants.size() >= 5), 64'(1));
    for (int k = 0; k < 5 && k < grants.size(); k++)
      check("r18_order", 64'(grants[k]), 64'(k % NREQ));

    // Illegal command code.
    do_reset();
    busy = '0; finish = '0;
    req_valid = 4'b0010;
    req_cmd[1*CSIZE +: CSIZE] = 4'd15;
    for (int t = 1; t <= 4; t++) begin
      step();
      if (t == 1) begin
        check("r19_ready", 64'(req_ready), 64'(4'b0010));
        check("r19_err", 64'(req_err), 64'(4'b0010));
      end
      check("r19_req", 64'(request), 64'(0));
      req_valid &= ~e_ready;
    end

    // Executor never answers: timeout, then the next requester.
    do_reset();
    req_valid = 4'b1100;
    req_cmd[2*CSIZE +: CSIZE] = 4'd5;
    req_cmd[3*CSIZE +: CSIZE] = 4'd6;
    t_r = -1; t_e = -1; t_r3 = -1; req_at_e = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      step();
      if (req_ready[2] && t_r < 0) t_r = t;
      if (req_err[2] && t_e < 0) begin t_e = t; req_at_e = request; end
      if (req_ready[3] && t_r3 < 0) t_r3 = t;
      req_valid &= ~e_ready;
    end
    check("r20_tmo", 64'(t_e - t_r), 64'(TMO));
    check("r20_req_lo", 64'(req_at_e), 64'(0));
    check("r20_next", 64'(t_r3), 64'(t_e + 1));

    // Finish on the timeout edge wins; a finish on another index does not.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      req_valid = 4'b0001;
      req_cmd[0*CSIZE +: CSIZE] = 4'd2;
      for (int t = 1; t <= 22; t++) begin
        step();
        if (t == 21) begin
          check("r21_done", 64'(req_done), 64'(pass == 0 ? 4'b0001 : 4'b0000));
          check("r21_err", 64'(req_err), 64'(pass == 0 ? 4'b0000 : 4'b0001));
        end
        req_valid &= ~e_ready;
        finish = (t == 20) ? (pass == 0 ? 8'h04 : 8'h08) : 8'h00;
      end
      finish = '0;
    end

    // Reset while waiting for finish.
    do_reset();
    req_valid = 4'b0100;
    req_cmd[2*CSIZE +: CSIZE] = 4'd1;
    step();
    req_valid &= ~e_ready;
    busy = 8'h02;
    step();
    busy = '0;
    step();
    check("r22_wait", 64'(request), 64'(0));
    req_valid = 4'b1001;
    req_cmd[0*CSIZE +: CSIZE] = 4'd4;
    req_cmd[3*CSIZE +: CSIZE] = 4'd5;
    do_reset();
    step();
    check("r22_grant", 64'(req_ready), 64'(4'b0001));
    req_valid &= ~e_ready;

    // Randomized traffic with occasional resets.
    do_reset();
    req_valid = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int i = 0; i < NREQ; i++) begin
        if (e_ready[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_cmd[i*CSIZE +: CSIZE] = ($urandom_range(0, 7) == 0) ?
            CSIZE'($urandom_range(SLIZE, 15)) : CSIZE'($urandom_range(0, SLIZE - 1));
          req_len[i*LSIZE +: LSIZE] = LSIZE'($urandom);
        end
      end
      busy   = SLIZE'($urandom & $urandom);
      finish = SLIZE'($urandom & $urandom & $urandom & $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
